bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
//   Parametrised N-master bus arbiter; successor to the fixed 4-master arbiter.
//   Takes a packed request vector. Drives a registered one-hot grant plus the encoded owner index.
//   Adds per-master bus lock and a bounded-tenure preemption timer.
//   Selectable round-robin or fixed-priority mode.
//   Sits between the bus masters (CPU, DMA, ...) and the shared bus address/data mux.
// PARAMETERS
//   NUM_MASTERS  4  number of masters, 2..16
//   IDX_W        2  width of grant_idx, = clog2(NUM_MASTERS)
//   MODE         0  0 = round-robin, 1 = fixed priority (index 0 highest)
//   MAX_HOLD     16 max tenure in cycles while others wait; 0 = unlimited (no preemption)
// PORTS
//   clk          in   1            system clock, rising edge
//   reset        in   1            asynchronous reset, active-low
//   m_req        in   NUM_MASTERS  bus request, bit i = master i, level-sensitive
//   m_lock       in   NUM_MASTERS  owner holds bus; blocks MAX_HOLD preemption (only the owner's bit matters)
//   m_grant      out  NUM_MASTERS  one-hot grant, registered; all-zero when idle
//   grant_valid  out  1            1 when any grant bit is set
//   grant_idx    out  IDX_W        index of current owner; holds last owner while idle
// BEHAVIOUR
//   Reset (reset==0, async):
//     - m_grant=0, grant_valid=0, grant_idx=0, hold_cnt=0.
//     - RR pointer = NUM_MASTERS-1, so master 0 wins the first round-robin search.
//     - State = IDLE.
//   States:
//     - IDLE: no owner.
//     - OWNED: exactly one grant bit set.
//   IDLE:
//     - Any m_req bit set at edge t -> winner granted from edge t; visible in cycle t+1.
//     - 1-cycle request-to-grant latency. State -> OWNED, hold_cnt=0.
//   OWNED, each edge:
//     - Release: owner's m_req==0.
//       - Re-arbitrate among all requesters.
//       - Hand off on the same edge; no idle bubble between owners.
//       - No requester -> IDLE, m_grant=0.
//     - Preempt: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, owner's m_lock==0, and another m_req set.
//       - Re-arbitrate excluding the owner; the owner loses the grant even if still requesting.
//     - Otherwise: grant unchanged; hold_cnt increments, saturating at MAX_HOLD-1.
//     - hold_cnt clears to 0 on every new grant.
//   Winner selection:
//     - RR: first set requester scanning owner+1, owner+2, ..., wrapping modulo NUM_MASTERS.
//       Pointer = last granted index.
//     - Fixed: lowest set index. Preemption in fixed mode picks the lowest index other than the owner.
//   Lock:
//     - Owner with m_lock=1 keeps the bus indefinitely while m_req=1.
//     - m_lock is ignored once the owner drops m_req.
//     - m_lock on a non-owner has no effect.
//   Invariants:
//     - m_grant is one-hot or zero at all times.
//     - grant_valid == |m_grant.
//     - grant_idx matches the set bit.
//     - A master whose m_req is 0 at an edge is never granted at that edge.
//   Simultaneous events:
//     - Owner release and preempt condition at the same edge: treat as release (all requesters eligible).
//     - Owner drops m_req while lone other requester present: hand off to it directly.
//   Reset mid-tenure: grant drops immediately (async). First arbitration after reset starts from master 0.
// TESTING (NUM_MASTERS=4, MAX_HOLD=4, MODE=0 unless stated)
//   1. Assert reset=0 mid-run with m_grant=4'b0100.
//      -> m_grant=0, grant_valid=0 immediately.
//      After release with m_req=4'b1111 -> m_grant=4'b0001 one cycle later.
//   2. Rotation: m_req=4'b1111, each owner drops req for one cycle after its grant.
//      -> grants 0001,0010,0100,1000,0001 in that order.
//      Each handoff occurs with no idle cycle.
//   3. Preemption: m_req=4'b0011 held, m_lock=0.
//      -> m0 holds exactly 4 cycles, then m_grant=4'b0010 for 4 cycles, then back to 4'b0001.
//   4. Lock: repeat scenario 3 with m_lock=4'b0001.
//      -> m_grant stays 4'b0001 for 20+ cycles; drop m_req[0] -> m_grant=4'b0010 next cycle.
//   5. MODE=1, m_req=4'b1110, then m_req[0] raised while m2 owns.
//      -> grant 4'b0010 first.
//      -> m0 gets the bus only after release or after MAX_HOLD expiry of the current owner.
//   6. Single requester m_req=4'b1000 for 10 cycles: no preemption (no other request), grant_idx=3 throughout.
//      Then m_req=0 -> grant_valid=0, grant_idx stays 3.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter: round-robin or fixed priority, with owner lock and bounded-tenure preemption.
// One-cycle request-to-grant latency. Handoff happens on the release edge itself, so there is no idle cycle between owners.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = 2,
  parameter int MODE        = 0,
  parameter int MAX_HOLD    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_lock,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx
);

  localparam int HC_W      = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [HC_W-1:0]        hold_cnt;

  logic                   owner_req;
  logic                   hold_expired;
  logic                   release_ev;
  logic                   preempt_ev;
  logic [NUM_MASTERS-1:0] others;
  logic [NUM_MASTERS-1:0] cand;
  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_MASTERS-1:0] win_onehot;
  int                     scan;

  always_comb begin
    owner_req    = (state == OWNED) && m_req[grant_idx];
    release_ev   = (state == OWNED) && !m_req[grant_idx];
    hold_expired = (MAX_HOLD != 0) && (hold_cnt == HC_W'(HOLD_LAST));
    others       = m_req & ~m_grant;
    // A locked owner keeps the bus; a release always wins over preemption.
    preempt_ev   = owner_req && hold_expired && !m_lock[grant_idx] && (|others);
    cand         = preempt_ev ? others : m_req;

    win_vld = 1'b0;
    win_idx = '0;
    scan    = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (MODE == 1) begin
        scan = i;
      end else begin
        scan = int'(rr_ptr) + i + 1;
        if (scan >= NUM_MASTERS) scan = scan - NUM_MASTERS;
      end
      if (!win_vld && cand[IDX_W'(scan)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(scan);
      end
    end
    win_onehot = NUM_MASTERS'(1) << win_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      m_grant     <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      rr_ptr      <= LAST_IDX;
      hold_cnt    <= '0;
    end else if (state == IDLE || release_ev || preempt_ev) begin
      hold_cnt <= '0;
      if (win_vld) begin
        state       <= OWNED;
        m_grant     <= win_onehot;
        grant_valid <= 1'b1;
        grant_idx   <= win_idx;
        rr_ptr      <= win_idx;
      end else begin
        // grant_idx deliberately keeps the last owner while idle.
        state       <= IDLE;
        m_grant     <= '0;
        grant_valid <= 1'b0;
      end
    end else if (hold_cnt != HC_W'(HOLD_LAST)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: round-robin instance plus a fixed-priority instance on shared stimulus.
module tb_bus_arbiter_rr;

  logic       clk;
  logic       reset;
  logic [3:0] m_req;
  logic [3:0] m_lock;

  logic [3:0] g_rr, g_fix;
  logic       v_rr, v_fix;
  logic [1:0] i_rr, i_fix;

  int n_chk  = 0;
  int n_pass = 0;

  bus_arbiter_rr #(.NUM_MASTERS(4), .IDX_W(2), .MODE(0), .MAX_HOLD(4)) u_rr (
    .clk(clk), .reset(reset), .m_req(m_req), .m_lock(m_lock),
    .m_grant(g_rr), .grant_valid(v_rr), .grant_idx(i_rr)
  );

  bus_arbiter_rr #(.NUM_MASTERS(4), .IDX_W(2), .MODE(1), .MAX_HOLD(4)) u_fix (
    .clk(clk), .reset(reset), .m_req(m_req), .m_lock(m_lock),
    .m_grant(g_fix), .grant_valid(v_fix), .grant_idx(i_fix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset  = 1'b0;
    m_req  = '0;
    m_lock = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] rot_exp [4];
    logic [3:0] pre_exp;
    int         hits;
    int         idx_ok;

    reset  = 1'b0;
    m_req  = '0;
    m_lock = '0;
    tick();
    tick();
    chk("rst_grant", 32'(g_rr), 32'h0);
    chk("rst_valid", 32'(v_rr), 32'h0);
    chk("rst_idx",   32'(i_rr), 32'h0);
    reset = 1'b1;

    // 1: async reset mid-tenure, then master 0 wins first
    m_req = 4'b0100;
    tick();
    chk("t1_pre_grant", 32'(g_rr), 32'h4);
    tick();
    reset = 1'b0;
    #1;
    chk("t1_async_grant", 32'(g_rr), 32'h0);
    chk("t1_async_valid", 32'(v_rr), 32'h0);
    m_req = 4'b1111;
    #2;
    reset = 1'b1;
    tick();
    chk("t1_first_grant", 32'(g_rr), 32'h1);
    chk("t1_first_idx",   32'(i_rr), 32'h0);

    // 2: rotation with no idle bubbles
    rot_exp[0] = 4'b0010;
    rot_exp[1] = 4'b0100;
    rot_exp[2] = 4'b1000;
    rot_exp[3] = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      m_req = 4'b1111 & ~g_rr;
      tick();
      chk($sformatf("t2_rot%0d", k), 32'(g_rr), 32'(rot_exp[k]));
      chk($sformatf("t2_vld%0d", k), 32'(v_rr), 32'h1);
    end
    m_req = 4'b1111;

    // 3: tenure-bounded preemption between m0 and m1
    do_reset();
    m_req = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      tick();
      pre_exp = (c < 4) ? 4'b0001 : (c < 8) ? 4'b0010 : 4'b0001;
      chk($sformatf("t3_cyc%0d", c), 32'(g_rr), 32'(pre_exp));
    end

    // 4: owner lock blocks preemption
    do_reset();
    m_lock = 4'b0001;
    m_req  = 4'b0011;
    hits   = 0;
    for (int c = 0; c < 22; c++) begin
      tick();
      if (g_rr == 4'b0001) hits++;
    end
    chk("t4_locked_cycles", 32'(hits), 32'd22);
    m_req = 4'b0010;
    tick();
    chk("t4_handoff", 32'(g_rr), 32'h2);

    // 6: lone requester never preempted, idx held when idle
    do_reset();
    m_req  = 4'b1000;
    hits   = 0;
    idx_ok = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (g_rr == 4'b1000) hits++;
      if (i_rr == 2'd3) idx_ok++;
    end
    chk("t6_grant_cycles", 32'(hits), 32'd10);
    chk("t6_idx_cycles",   32'(idx_ok), 32'd10);
    m_req = 4'b0000;
    tick();
    chk("t6_idle_valid", 32'(v_rr), 32'h0);
    chk("t6_idle_grant", 32'(g_rr), 32'h0);
    chk("t6_idle_idx",   32'(i_rr), 32'h3);

    // 5: fixed priority, late m0 waits for tenure expiry
    do_reset();
    m_req = 4'b1110;
    tick();
    chk("t5_first", 32'(g_fix), 32'h2);
    m_req = 4'b1100;
    tick();
    chk("t5_m2_owns", 32'(g_fix), 32'h4);
    m_req = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t5_m2_hold%0d", c), 32'(g_fix), 32'h4);
    end
    tick();
    chk("t5_m0_preempts", 32'(g_fix), 32'h1);
    chk("t5_m0_idx",      32'(i_fix), 32'h0);
    m_req = 4'b1100;
    tick();
    chk("t5_release", 32'(g_fix), 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
